// File: rtl/pwd_entry.sv
// -----------------------------------------------------------------------------
// pwd_entry -- password entry sequencer feeding the safe controller.
//
// Turns debounced single-cycle button pulses into a DIGITS-long BCD code,
// one digit at a time, shows the active digit on a 7-segment pattern and
// offers the finished code on a valid/ready handshake.
//
// Parameters:
//   DIGITS       number of BCD digits entered (2..4)
//   TIMEOUT_CYC  idle cycles in ENTRY before the entry is abandoned
//
// Optional feature macro:
//   PWD_ENTRY_TIMEOUT_EN  builds the idle counter; an ENTRY left untouched for
//                         TIMEOUT_CYC cycles is cleared back to IDLE.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   btn_inc    pulse: increment the active digit (0..9 wrap)
//   btn_next   pulse: commit the active digit, advance position (saturating)
//   btn_clr    pulse: discard the entry
//   btn_ok     pulse: commit the active digit and submit the code
//   pwd_ready  downstream accepts the code
//   pwd_data   BCD code, digit 0 in [15:12], unused low nibbles 0
//   pwd_valid  code is available
//   pos        index of the active digit
//   seg_cur    7-segment pattern of the active digit (0 in IDLE/SUBMIT)
//   busy       state is not IDLE
// -----------------------------------------------------------------------------
module pwd_entry #(
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 60_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_next,
  input  logic        btn_clr,
  input  logic        btn_ok,
  input  logic        pwd_ready,
  output logic [15:0] pwd_data,
  output logic        pwd_valid,
  output logic [1:0]  pos,
  output logic [8:0]  seg_cur,
  output logic        busy
);

  if (DIGITS < 2 || DIGITS > 4 || TIMEOUT_CYC < 1) begin : g_param_err
    $error("pwd_entry: DIGITS must be 2..4 and TIMEOUT_CYC at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_SUBMIT = 2'd2
  } state_t;

  localparam logic [1:0] LAST_POS = 2'(DIGITS - 1);
  localparam logic [8:0] SEG_ZERO = 9'h03f;

  state_t      r_state;
  logic [3:0]  r_digit;
  logic [1:0]  r_pos;
  logic [15:0] r_code;
  logic        r_valid;
  logic [8:0]  r_seg;
  logic        r_busy;

  logic        w_any_btn;
  logic        w_timeout;
  logic [3:0]  w_digit_inc;

  function automatic logic [8:0] seg7(input logic [3:0] d);
    logic [8:0] s;
    case (d)
      4'd0:    s = 9'h03f;
      4'd1:    s = 9'h006;
      4'd2:    s = 9'h05b;
      4'd3:    s = 9'h04f;
      4'd4:    s = 9'h066;
      4'd5:    s = 9'h06d;
      4'd6:    s = 9'h07d;
      4'd7:    s = 9'h007;
      4'd8:    s = 9'h07f;
      4'd9:    s = 9'h06f;
      default: s = 9'h000;
    endcase
    return s;
  endfunction

  // Digit 0 lives in the top nibble so a short code leaves low nibbles at 0.
  function automatic logic [15:0] set_nibble(input logic [15:0] code,
                                             input logic [1:0]  p,
                                             input logic [3:0]  d);
    logic [15:0] res;
    res = code;
    case (p)
      2'd0:    res[15:12] = d;
      2'd1:    res[11:8]  = d;
      2'd2:    res[7:4]   = d;
      default: res[3:0]   = d;
    endcase
    return res;
  endfunction

  assign w_any_btn   = btn_inc | btn_next | btn_clr | btn_ok;
  assign w_digit_inc = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;

`ifdef PWD_ENTRY_TIMEOUT_EN
  localparam int             CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_idle_cnt;

  // Counts only while ENTRY sits untouched; saturates so the timeout
  // condition stays asserted until acted on.
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_ENTRY) || w_any_btn) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != CNT_MAX) begin
      r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end
  end

  // A pulse in the expiry cycle wins over the timeout.
  assign w_timeout = (r_state == S_ENTRY) && (r_idle_cnt == CNT_MAX) && !w_any_btn;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_digit <= 4'd0;
      r_pos   <= 2'd0;
      r_code  <= 16'd0;
      r_valid <= 1'b0;
      r_seg   <= SEG_ZERO;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The entering btn_inc also counts as the first increment.
          if (btn_inc || btn_next) begin
            r_state <= S_ENTRY;
            r_busy  <= 1'b1;
            r_pos   <= 2'd0;
            r_digit <= btn_inc ? 4'd1 : 4'd0;
            r_seg   <= btn_inc ? seg7(4'd1) : SEG_ZERO;
          end
        end
        S_ENTRY: begin
          // Priority clr > ok > next > inc; only the winner acts.
          if (btn_clr || w_timeout) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_code  <= 16'd0;
            r_pos   <= 2'd0;
            r_digit <= 4'd0;
            r_seg   <= SEG_ZERO;
          end else if (btn_ok) begin
            r_code  <= set_nibble(r_code, r_pos, r_digit);
            r_state <= S_SUBMIT;
            r_valid <= 1'b1;
            r_seg   <= SEG_ZERO;
          end else if (btn_next) begin
            r_code  <= set_nibble(r_code, r_pos, r_digit);
            if (r_pos != LAST_POS) begin
              r_pos <= r_pos + 2'd1;
            end
            r_digit <= 4'd0;
            r_seg   <= SEG_ZERO;
          end else if (btn_inc) begin
            r_digit <= w_digit_inc;
            r_seg   <= seg7(w_digit_inc);
          end
        end
        S_SUBMIT: begin
          // Code held until the transfer edge; every button is ignored here.
          if (r_valid && pwd_ready) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_code  <= 16'd0;
            r_pos   <= 2'd0;
            r_digit <= 4'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_seg   <= SEG_ZERO;
        end
      endcase
    end
  end

  assign pwd_data  = r_code;
  assign pwd_valid = r_valid;
  assign pos       = r_pos;
  assign seg_cur   = r_seg;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pwd_entry.sv
module tb_pwd_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_inc, btn_next, btn_clr, btn_ok, pwd_ready;
  logic [15:0] pwd_data;
  logic        pwd_valid;
  logic [1:0]  pos;
  logic [8:0]  seg_cur;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwd_entry #(.DIGITS(4), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_inc   (btn_inc),
    .btn_next  (btn_next),
    .btn_clr   (btn_clr),
    .btn_ok    (btn_ok),
    .pwd_ready (pwd_ready),
    .pwd_data  (pwd_data),
    .pwd_valid (pwd_valid),
    .pos       (pos),
    .seg_cur   (seg_cur),
    .busy      (busy)
  );

  typedef struct {
    string       name;
    logic        inc, nxt, clr, ok, rdy;
    logic [15:0] data;
    logic        valid;
    logic [1:0]  pos;
    logic        chk_pos;
    logic [8:0]  seg;
    logic        busy;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] segt[10];

  task automatic add(input string nm, input logic i, input logic n, input logic c,
                     input logic o, input logic r, input logic [15:0] d,
                     input logic v, input logic [1:0] p, input logic cp,
                     input logic [8:0] s, input logic b);
    vec_t e;
    e.name = nm; e.inc = i; e.nxt = n; e.clr = c; e.ok = o; e.rdy = r;
    e.data = d; e.valid = v; e.pos = p; e.chk_pos = cp; e.seg = s; e.busy = b;
    vecs.push_back(e);
  endtask

  // One rising edge with the given pulses; outputs are stable 1 ns later.
  task automatic step(input logic i, input logic n, input logic c, input logic o);
    btn_inc = i; btn_next = n; btn_clr = c; btn_ok = o;
    @(posedge clk);
    #1;
    btn_inc = 1'b0; btn_next = 1'b0; btn_clr = 1'b0; btn_ok = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [15:0] d, input logic v,
                     input logic [1:0] p, input logic cp, input logic [8:0] s,
                     input logic b);
    checks++;
    if (pwd_data !== d || pwd_valid !== v || (cp && pos !== p) ||
        seg_cur !== s || busy !== b) begin
      failures++;
      $display("FAIL %s: got data=%h valid=%b pos=%0d seg=%h busy=%b, want data=%h valid=%b pos=%0d%s seg=%h busy=%b",
               nm, pwd_data, pwd_valid, pos, seg_cur, busy,
               d, v, p, cp ? "" : "(any)", s, b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    segt = '{9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
             9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f};

    // Sequence A: inc, next, next, inc x9, next, ok -> 1,0,9,0
    add("A_inc0", 1,0,0,0,1, 16'h0000, 0, 2'd0, 1, 9'h006, 1);
    add("A_nxt0", 0,1,0,0,1, 16'h1000, 0, 2'd1, 1, 9'h03f, 1);
    add("A_nxt1", 0,1,0,0,1, 16'h1000, 0, 2'd2, 1, 9'h03f, 1);
    for (int k = 1; k <= 9; k++)
      add("A_inc", 1,0,0,0,1, 16'h1000, 0, 2'd2, 1, segt[k], 1);
    add("A_nxt2", 0,1,0,0,1, 16'h1090, 0, 2'd3, 1, 9'h03f, 1);
    add("A_ok",   0,0,0,1,1, 16'h1090, 1, 2'd3, 1, 9'h03f, 1);
    add("A_done", 0,0,0,0,1, 16'h0000, 0, 2'd0, 0, 9'h03f, 0);
    add("A_idle", 0,0,0,0,1, 16'h0000, 0, 2'd0, 0, 9'h03f, 0);

    // Sequence B: inc, next x3, inc x9, ok -> 1,0,0,9
    add("B_inc0", 1,0,0,0,1, 16'h0000, 0, 2'd0, 1, 9'h006, 1);
    add("B_nxt0", 0,1,0,0,1, 16'h1000, 0, 2'd1, 1, 9'h03f, 1);
    add("B_nxt1", 0,1,0,0,1, 16'h1000, 0, 2'd2, 1, 9'h03f, 1);
    add("B_nxt2", 0,1,0,0,1, 16'h1000, 0, 2'd3, 1, 9'h03f, 1);
    for (int k = 1; k <= 9; k++)
      add("B_inc", 1,0,0,0,1, 16'h1000, 0, 2'd3, 1, segt[k], 1);
    add("B_ok",   0,0,0,1,1, 16'h1009, 1, 2'd3, 1, 9'h03f, 1);
    add("B_done", 0,0,0,0,1, 16'h0000, 0, 2'd0, 0, 9'h03f, 0);

    // Sequence C: priority among simultaneous pulses, IDLE ignores ok/clr
    add("C_inc0", 1,0,0,0,1, 16'h0000, 0, 2'd0, 1, 9'h006, 1);
    add("C_inc1", 1,0,0,0,1, 16'h0000, 0, 2'd0, 1, 9'h05b, 1);
    add("C_inc2", 1,0,0,0,1, 16'h0000, 0, 2'd0, 1, 9'h04f, 1);
    add("C_nxt_over_inc", 1,1,0,0,1, 16'h3000, 0, 2'd1, 1, 9'h03f, 1);
    add("C_ok_over_all",  1,1,0,1,1, 16'h3000, 1, 2'd1, 1, 9'h03f, 1);
    add("C_done",     0,0,0,0,1, 16'h0000, 0, 2'd0, 0, 9'h03f, 0);
    add("C_idle_ok",  0,0,0,1,1, 16'h0000, 0, 2'd0, 0, 9'h03f, 0);
    add("C_idle_clr", 0,0,1,0,1, 16'h0000, 0, 2'd0, 0, 9'h03f, 0);

    rst = 1'b1;
    btn_inc = 1'b0; btn_next = 1'b0; btn_clr = 1'b0; btn_ok = 1'b0;
    pwd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 16'h0000, 0, 2'd0, 1, 9'h03f, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      pwd_ready = vecs[i].rdy;
      step(vecs[i].inc, vecs[i].nxt, vecs[i].clr, vecs[i].ok);
      chk(vecs[i].name, vecs[i].data, vecs[i].valid, vecs[i].pos,
          vecs[i].chk_pos, vecs[i].seg, vecs[i].busy);
    end

    // inc x10 from IDLE: 1..9 then wrap to 0
    pwd_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1, 0, 0, 0);
      chk("wrap_inc", 16'h0000, 0, 2'd0, 1, segt[k % 10], 1);
    end
    step(0, 0, 1, 0);
    chk("wrap_clr", 16'h0000, 0, 2'd0, 1, 9'h03f, 0);

    // clr and ok together: clr wins, nothing submitted
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("clrok_pre", 16'h1000, 0, 2'd1, 1, 9'h03f, 1);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    chk("clrok", 16'h0000, 0, 2'd0, 1, 9'h03f, 0);
    step(0, 0, 0, 0);
    chk("clrok_after", 16'h0000, 0, 2'd0, 1, 9'h03f, 0);

    // Backpressure: submit 4200 with ready low, buttons ignored in SUBMIT
    pwd_ready = 1'b0;
    repeat (4) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("bp_submit", 16'h4200, 1, 2'd2, 1, 9'h03f, 1);
    for (int k = 0; k < 10; k++) begin
      step(k % 4 == 0, k % 4 == 1, k % 4 == 2, k % 4 == 3);
      chk("bp_hold", 16'h4200, 1, 2'd2, 0, 9'h03f, 1);
    end
    pwd_ready = 1'b1;
    step(0, 0, 0, 0);
    chk("bp_xfer", 16'h0000, 0, 2'd0, 0, 9'h03f, 0);

    // next x6: pos saturates at 3, data stays 0 until ok
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 0);
      chk("next_sat", 16'h0000, 0, (k > 3) ? 2'd3 : 2'(k), 1, 9'h03f, 1);
    end
    repeat (5) step(1, 0, 0, 0);
    chk("next_sat_inc", 16'h0000, 0, 2'd3, 1, 9'h06d, 1);
    step(0, 0, 0, 1);
    chk("next_sat_ok", 16'h0005, 1, 2'd3, 1, 9'h03f, 1);
    step(0, 0, 0, 0);
    chk("next_sat_done", 16'h0000, 0, 2'd0, 0, 9'h03f, 0);

    // Reset wins mid-handshake
    pwd_ready = 1'b0;
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("rst_pre", 16'h1000, 1, 2'd0, 1, 9'h03f, 1);
    rst = 1'b1;
    step(0, 0, 0, 0);
    chk("rst_mid", 16'h0000, 0, 2'd0, 1, 9'h03f, 0);
    rst = 1'b0;
    pwd_ready = 1'b1;

    // Idle timeout behaviour
    step(1, 0, 0, 0);
    chk("to_enter", 16'h0000, 0, 2'd0, 1, 9'h006, 1);
`ifdef PWD_ENTRY_TIMEOUT_EN
    for (int k = 1; k <= 17; k++) begin
      step(0, 0, 0, 0);
      if (k < 17) chk("to_wait", 16'h0000, 0, 2'd0, 1, 9'h006, 1);
      else        chk("to_fire", 16'h0000, 0, 2'd0, 1, 9'h03f, 0);
    end
    step(1, 0, 0, 0);
    repeat (16) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("to_skip", 16'h0000, 0, 2'd0, 1, 9'h05b, 1);
    step(0, 0, 1, 0);
`else
    repeat (100) step(0, 0, 0, 0);
    chk("to_none", 16'h0000, 0, 2'd0, 1, 9'h006, 1);
    step(0, 0, 1, 0);
`endif
    chk("to_end", 16'h0000, 0, 2'd0, 1, 9'h03f, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
